// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM plus MMIO window (console TX FIFO, LEDs,
// cycle counter) behind the core's single memory port.
// Optional build macro: CYCLE_COUNTER_EN adds the 32-bit cycle counter read at
// MMIO offset 0xC; without it that register reads 0 but stays mapped.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned LED_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Address,
    input  logic [31:0]      WriteData,
    input  logic             MemWrite,
    output logic [31:0]      ReadData,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [LED_W-1:0] leds,
    output logic             bus_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] SEL_TX     = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_LEDS   = 2'd2;
    localparam logic [1:0] SEL_CYCLE  = 2'd3;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [29:0]   prev_addr;
    logic          prev_valid;

    logic          is_ram_c;
    logic          is_mmio_c;
    logic          unmapped_c;
    logic [1:0]    sel_c;
    logic          wr_en_c;
    logic          push_req_c;
    logic          push_ok_c;
    logic          pop_c;
    logic          full_c;
    logic          empty_c;
    logic          status_wr_c;
    logic          held_c;
    logic [31:0]   status_c;
    logic [31:0]   cycle_c;
    logic [31:0]   rdata_c;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^Address[1:0];

    // Address decode and strobes; writes during reset are suppressed
    always_comb begin
        is_ram_c    = !Address[31] && (Address[30:2] < 29'(DEPTH_WORDS));
        is_mmio_c   = (Address[31:4] == 28'h8000000);
        unmapped_c  = !is_ram_c && !is_mmio_c;
        sel_c       = Address[3:2];
        wr_en_c     = MemWrite && !reset;
        full_c      = (count == CW'(FIFO_DEPTH));
        empty_c     = (count == '0);
        pop_c       = !empty_c && tx_ready;
        push_req_c  = wr_en_c && is_mmio_c && (sel_c == SEL_TX);
        push_ok_c   = push_req_c && (!full_c || pop_c);
        status_wr_c = wr_en_c && is_mmio_c && (sel_c == SEL_STATUS);
        held_c      = prev_valid && (prev_addr == Address[31:2]);
        status_c    = {24'b0, 4'(count), overflow, full_c, empty_c, 1'b0};
    end

    assign tx_valid = !empty_c;
    assign tx_data  = fifo_mem[rd_ptr];

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clk) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end

    assign cycle_c = cycle_q;
`else
    assign cycle_c = '0;
`endif

    // Read mux: side-effect free, sampled pre-edge
    always_comb begin
        rdata_c = '0;
        if (is_ram_c) begin
            rdata_c = mem[Address[AW+1:2]];
        end else if (is_mmio_c) begin
            case (sel_c)
                SEL_STATUS: rdata_c = status_c;
                SEL_LEDS:   rdata_c = 32'(leds);
                SEL_CYCLE:  rdata_c = cycle_c;
                default:    rdata_c = '0;
            endcase
        end
    end

    // RAM write port; old word is returned on a same-cycle read
    always_ff @(posedge clk) begin
        if (wr_en_c && is_ram_c) mem[Address[AW+1:2]] <= WriteData;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_c) fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok_c) - CW'(pop_c);
            if (status_wr_c)                       overflow <= 1'b0;
            else if (push_req_c && full_c && !pop_c) overflow <= 1'b1;
        end
    end

    // Read data, LED register, held-address tracker and sticky bus error
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData   <= '0;
            leds       <= '0;
            bus_err    <= 1'b0;
            prev_addr  <= '0;
            prev_valid <= 1'b0;
        end else begin
            ReadData   <= rdata_c;
            prev_addr  <= Address[31:2];
            prev_valid <= 1'b1;
            if (wr_en_c && is_mmio_c && (sel_c == SEL_LEDS))
                leds <= WriteData[LED_W-1:0];
            if (status_wr_c)
                bus_err <= 1'b0;
            else if (unmapped_c && (MemWrite || held_c))
                bus_err <= 1'b1;
        end
    end

endmodule
